// File: rtl/fifo_sample_averager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sample_averager_pkg
// Description : Shared types and constants for the FIFO sample averager.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sample_averager_pkg;

    localparam int c_SAMPLE_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_POP     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_EMIT    = 2'd3
    } avg_state_t;

    // Wide enough for WIN full-scale samples with no overflow.
    function automatic int sum_width(input int data_width, input int log2_win);
        return data_width + log2_win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sample_averager_window_mem.sv
`default_nettype none
// ============================================================================
// Module      : avg_window_mem
// Description : WIN x DATA_WIDTH history register file, one sync write port,
//               one async read port and a synchronous clear-all.
// Revision    : 1.0 - initial release
// ============================================================================
module avg_window_mem
    import fifo_sample_averager_pkg::*;
#(
    parameter int DATA_WIDTH = c_SAMPLE_WIDTH,
    parameter int LOG2_WIN   = 2
) (
    input  logic                  clk2,
    input  logic                  i_clr,
    input  logic                  i_wr_en,
    input  logic [LOG2_WIN-1:0]   i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [LOG2_WIN-1:0]   i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << LOG2_WIN;

    logic [DATA_WIDTH-1:0] r_entry [c_DEPTH];

    // Write beats clear so a sample can land in a window flushed the same edge.
    always_ff @(posedge clk2) begin
        for (int i = 0; i < c_DEPTH; i++) begin
            if (i_wr_en && (i_wr_idx == LOG2_WIN'(i))) begin
                r_entry[i] <= i_wr_data;
            end else if (i_clr) begin
                r_entry[i] <= '0;
            end
        end
    end

    assign o_rd_data = r_entry[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/fifo_sample_averager.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sample_averager
// Description : Pops samples from the CDC FIFO read port and emits a moving
//               average over 2^LOG2_WIN samples on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sample_averager
    import fifo_sample_averager_pkg::*;
#(
    parameter int DATA_WIDTH = c_SAMPLE_WIDTH,
    parameter int LOG2_WIN   = 2
) (
    input  logic                  clk2,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] avg_data,
    output logic                  avg_valid,
    input  logic                  avg_ready,
    output logic                  win_full
);

    localparam int                c_SUM_W = sum_width(DATA_WIDTH, LOG2_WIN);
    localparam logic [LOG2_WIN:0] c_WIN   = {1'b1, {LOG2_WIN{1'b0}}};

    avg_state_t            r_state;
    avg_state_t            w_state_next;
    logic [c_SUM_W-1:0]    r_sum;
    logic [LOG2_WIN-1:0]   r_idx;
    logic [LOG2_WIN:0]     r_fill;
    logic                  r_win_full;
    logic [DATA_WIDTH-1:0] r_avg_data;

    logic [DATA_WIDTH-1:0] w_hist_rd;
    logic [DATA_WIDTH-1:0] w_oldest;
    logic [c_SUM_W-1:0]    w_base_sum;
    logic [c_SUM_W-1:0]    w_sum_next;
    logic [LOG2_WIN-1:0]   w_base_idx;
    logic [LOG2_WIN:0]     w_base_fill;
    logic [LOG2_WIN:0]     w_fill_next;
    logic                  w_full_next;
    logic                  w_capture;

    assign w_capture = (r_state == ST_CAPTURE);

    // A clear during capture means the new sample starts a fresh window.
    always_comb begin
        w_base_sum  = r_sum;
        w_base_idx  = r_idx;
        w_base_fill = r_fill;
        w_oldest    = w_hist_rd;
        if (clear) begin
            w_base_sum  = '0;
            w_base_idx  = '0;
            w_base_fill = '0;
            w_oldest    = '0;
        end
    end

    assign w_sum_next  = w_base_sum - {{LOG2_WIN{1'b0}}, w_oldest}
                                    + {{LOG2_WIN{1'b0}}, fifo_data};
    assign w_fill_next = (w_base_fill == c_WIN) ? c_WIN : (w_base_fill + 1'b1);
    assign w_full_next = (w_fill_next == c_WIN);

    avg_window_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_WIN   (LOG2_WIN)
    ) u_window_mem (
        .clk2      (clk2),
        .i_clr     (reset | clear),
        .i_wr_en   (w_capture & ~reset),
        .i_wr_idx  (w_base_idx),
        .i_wr_data (fifo_data),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_hist_rd)
    );

    always_ff @(posedge clk2) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!clear && !fifo_empty && !avg_valid) begin
                    w_state_next = ST_POP;
                end
            end
            ST_POP:     w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = w_full_next ? ST_EMIT : ST_IDLE;
            ST_EMIT: begin
                if (clear || avg_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (reset) begin
            r_sum      <= '0;
            r_idx      <= '0;
            r_fill     <= '0;
            r_win_full <= 1'b0;
            r_avg_data <= '0;
        end else if (w_capture) begin
            r_sum      <= w_sum_next;
            r_idx      <= w_base_idx + 1'b1;
            r_fill     <= w_fill_next;
            r_win_full <= w_full_next;
            if (w_full_next) begin
                r_avg_data <= w_sum_next[c_SUM_W-1:LOG2_WIN];
            end
        end else if (clear) begin
            r_sum      <= '0;
            r_idx      <= '0;
            r_fill     <= '0;
            r_win_full <= 1'b0;
        end
    end

    assign fifo_rd_en = (r_state == ST_POP);
    assign avg_valid  = (r_state == ST_EMIT);
    assign avg_data   = r_avg_data;
    assign win_full   = r_win_full;

endmodule
`default_nettype wire
